// File: rtl/spi_reg_bridge_if.sv
// SPI pin and register-bus bundle for spi_reg_bridge.
// The bridge uses the slave modport. The master modport is the environment:
// the external SPI master together with the register file.
//
// Handshake: the register side has no backpressure.
//  - wr_en is a single-cycle strobe. addr and wr_data qualify it in the same cycle.
//  - rd_req is a single-cycle strobe for addr.
//  - The responder registers rd_data on the clock edge that sees rd_req.
//    The bridge captures rd_data on the following edge.
//  - wr_en and rd_req are never high together.
// dbg_state exposes the bridge FSM encoding:
//  0 = IDLE, 1 = CMD, 2 = WDATA, 3 = RDATA.
interface spi_reg_bridge_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              frame_err;
    logic [1:0]        dbg_state;

    modport slave (
        input  sclk, cs_n, mosi, rd_data,
        output miso, miso_oe, addr, wr_en, wr_data, rd_req, busy, frame_err, dbg_state
    );

    modport master (
        output sclk, cs_n, mosi, rd_data,
        input  miso, miso_oe, addr, wr_en, wr_data, rd_req, busy, frame_err, dbg_state
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI slave to register-bus bridge with burst access.
//
// Frame layout:
//  - A frame opens with a command word.
//    Bit DATA_W-1 selects the direction: 1 = read, 0 = write.
//    The low ADDR_W bits give the start address.
//  - Data words follow the command word.
//  - The address auto-increments after each data word and wraps to 0.
//
// Timing and configuration:
//  - sclk, cs_n and mosi are oversampled in the clk domain.
//  - Word width, SPI mode (CPOL/CPHA) and bit order are parameters.
//  - Optional feature macro: SPI_REG_BRIDGE_FRAMEERR_EN.
//    When it is defined, frame_err flags frames that end mid-word.
module spi_reg_bridge #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_reg_bridge_if.slave bus
);
    localparam int              CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic            SCLK_IDLE = (CPOL != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    // Synchroniser chains and edge-detect history.
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    // Frame state.
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              miso_q, miso_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_req_q, rd_req_d;
    logic              rd_load_q, rd_load_d;
    logic              inc_pend_q, inc_pend_d;

    logic              sclk_s, cs_s, mosi_s;
    logic              sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic              sample_edge, shift_edge, cs_fall, cs_rise, word_done;
    logic [DATA_W-1:0] rx_word, tx_shifted;
    logic              tx_bit;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign lead_edge   = SCLK_IDLE ? sclk_fall : sclk_rise;
    assign trail_edge  = SCLK_IDLE ? sclk_rise : sclk_fall;
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    assign cs_fall     = cs_prev_q & ~cs_s;
    assign cs_rise     = ~cs_prev_q & cs_s;
    assign word_done   = sample_edge && (bit_cnt_q == LAST_BIT);

    assign rx_word    = (MSB_FIRST != 0) ? {rx_q[DATA_W-2:0], mosi_s} : {mosi_s, rx_q[DATA_W-1:1]};
    assign tx_bit     = (MSB_FIRST != 0) ? tx_q[DATA_W-1] : tx_q[0];
    assign tx_shifted = (MSB_FIRST != 0) ? {tx_q[DATA_W-2:0], 1'b0} : {1'b0, tx_q[DATA_W-1:1]};

    // Shift the pins through the synchronisers and remember the last synchronised levels.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
    end

    // Frame FSM: command decode, write/read bursts, and chip-select abort.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        rd_req_d   = 1'b0;
        rd_load_d  = rd_req_q;
        inc_pend_d = 1'b0;

        if (inc_pend_q) begin
            addr_d = addr_q + 1'b1;
        end
        if (rd_load_q) begin
            tx_d = bus.rd_data;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                end
            end
            CMD: begin
                if (sample_edge) begin
                    rx_d = rx_word;
                    if (word_done) begin
                        bit_cnt_d = '0;
                        addr_d    = rx_word[ADDR_W-1:0];
                        if (rx_word[DATA_W-1]) begin
                            state_d  = RDATA;
                            rd_req_d = 1'b1;
                        end else begin
                            state_d = WDATA;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            WDATA: begin
                if (sample_edge) begin
                    rx_d = rx_word;
                    if (word_done) begin
                        bit_cnt_d  = '0;
                        wr_data_d  = rx_word;
                        wr_en_d    = 1'b1;
                        inc_pend_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            RDATA: begin
                // Word boundaries follow the master's sample edges.
                // The next word is fetched well before the following shift edge.
                if (shift_edge) begin
                    miso_d = tx_bit;
                    tx_d   = tx_shifted;
                end
                if (sample_edge) begin
                    if (word_done) begin
                        bit_cnt_d = '0;
                        addr_d    = addr_q + 1'b1;
                        rd_req_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A completing write word still issues wr_en.
        // Any read prefetch is dropped.
        if (cs_rise && state_q != IDLE) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            rd_req_d  = 1'b0;
        end
    end

    // Register all state.
    // The cs chain resets low so a select held low through reset never looks like a fresh frame start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= SCLK_IDLE;
            cs_prev_q   <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            rd_req_q    <= 1'b0;
            rd_load_q   <= 1'b0;
            inc_pend_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            rd_req_q    <= rd_req_d;
            rd_load_q   <= rd_load_d;
            inc_pend_q  <= inc_pend_d;
        end
    end

`ifdef SPI_REG_BRIDGE_FRAMEERR_EN
    logic frame_err_q, frame_err_d;

    // Sticky flag: set when a frame ends mid-word, cleared when the next frame opens.
    always_comb begin
        frame_err_d = frame_err_q;
        if (state_q == IDLE && cs_fall) begin
            frame_err_d = 1'b0;
        end else if (state_q != IDLE && cs_rise && bit_cnt_q != '0 && !word_done) begin
            frame_err_d = 1'b1;
        end
    end

    // Register the framing error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.frame_err = frame_err_q;
`else
    assign bus.frame_err = 1'b0;
`endif

    assign bus.miso      = miso_q;
    assign bus.miso_oe   = (state_q == RDATA);
    assign bus.addr      = addr_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_req    = rd_req_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.dbg_state = state_q;
endmodule
